// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad emulator: sequence states,
// key-to-matrix mapping and the bounce LFSR parameters.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_PRESS_BOUNCE   = 3'd1,
    ST_HOLD           = 3'd2,
    ST_RELEASE_BOUNCE = 3'd3,
    ST_GAP            = 3'd4
  } kp_state_e;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_pos_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Feedback taps: bits 7, 5, 4 and 3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic key_pos_t key_to_pos(input logic [3:0] key);
    key_pos_t p;
    unique case (key)
      4'h1: p = '{row: 2'd0, col: 2'd0};
      4'h2: p = '{row: 2'd0, col: 2'd1};
      4'h3: p = '{row: 2'd0, col: 2'd2};
      4'hA: p = '{row: 2'd0, col: 2'd3};
      4'h4: p = '{row: 2'd1, col: 2'd0};
      4'h5: p = '{row: 2'd1, col: 2'd1};
      4'h6: p = '{row: 2'd1, col: 2'd2};
      4'hB: p = '{row: 2'd1, col: 2'd3};
      4'h7: p = '{row: 2'd2, col: 2'd0};
      4'h8: p = '{row: 2'd2, col: 2'd1};
      4'h9: p = '{row: 2'd2, col: 2'd2};
      4'hC: p = '{row: 2'd2, col: 2'd3};
      4'hE: p = '{row: 2'd3, col: 2'd0};
      4'h0: p = '{row: 2'd3, col: 2'd1};
      4'hF: p = '{row: 2'd3, col: 2'd2};
      default: p = '{row: 2'd3, col: 2'd3};  // 4'hD
    endcase
    return p;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/keypad_emulator_lfsr.sv
// 8-bit Fibonacci LFSR supplying pseudo-random contact chatter while bouncing.
module bounce_lfsr
  import keypad_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic bit0
);

  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= LFSR_SEED;
    end else if (en) begin
      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign bit0 = lfsr[0];

endmodule

// File: rtl/keypad_emulator.sv
// Responder side of a 4x4 matrix keypad: plays one bounced key press per
// accepted command and pulls the matching row low when its column is strobed.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int BOUNCE_CYCLES = 1000,
  parameter int HOLD_CYCLES   = 100000,
  parameter int GAP_CYCLES    = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  input  logic       cmd_valid,
  input  logic [3:0] cmd_key,
  output logic       cmd_ready,
  output logic       busy,
  output logic       done
);

  localparam int MAX_CYC = max3(BOUNCE_CYCLES, HOLD_CYCLES, GAP_CYCLES);
  localparam int CNT_W   = (MAX_CYC <= 2) ? 1 : $clog2(MAX_CYC);
  localparam bit HAS_BOUNCE = (BOUNCE_CYCLES > 0);

  // Counters hold "cycles remaining minus one" so a state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(HAS_BOUNCE ? BOUNCE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);

  kp_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             cnt_zero;
  logic             done_nx;
  logic             accept;
  logic [3:0]       key_q;
  key_pos_t         pos;
  logic             contact;
  logic             lfsr_en;
  logic             lfsr_bit;

  bounce_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en),
    .bit0  (lfsr_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      done  <= done_nx;
    end
  end

  // Key code is data: captured on accept only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      key_q <= cmd_key;
    end
  end

  assign cnt_zero = (cnt == '0);
  assign accept   = cmd_valid & cmd_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt_zero ? cnt : cnt - CNT_W'(1);
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = HAS_BOUNCE ? ST_PRESS_BOUNCE : ST_HOLD;
          cnt_nx   = HAS_BOUNCE ? BOUNCE_LOAD : HOLD_LOAD;
        end
      end
      ST_PRESS_BOUNCE: begin
        if (cnt_zero) begin
          state_nx = ST_HOLD;
          cnt_nx   = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          state_nx = HAS_BOUNCE ? ST_RELEASE_BOUNCE : ST_GAP;
          cnt_nx   = HAS_BOUNCE ? BOUNCE_LOAD : GAP_LOAD;
        end
      end
      ST_RELEASE_BOUNCE: begin
        if (cnt_zero) begin
          state_nx = ST_GAP;
          cnt_nx   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (cnt_zero) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  assign done_nx = (state == ST_GAP) && cnt_zero;
  assign pos     = key_to_pos(key_q);

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    lfsr_en   = (state == ST_PRESS_BOUNCE) || (state == ST_RELEASE_BOUNCE);
    unique case (state)
      ST_PRESS_BOUNCE, ST_RELEASE_BOUNCE: contact = lfsr_bit;
      ST_HOLD:                            contact = 1'b1;
      default:                            contact = 1'b0;
    endcase
    // Row drive is combinational from the column strobes: zero added latency.
    rows = 4'hF;
    if (contact && !cols[pos.col]) begin
      rows[pos.row] = 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench: two emulator configurations compared cycle by cycle
// against a position-in-sequence reference model, plus directed scenarios.
module tb_keypad_emulator;

  localparam int MB[2] = '{4, 0};
  localparam int MH[2] = '{8, 3};
  localparam int MG[2] = '{2, 1};
  localparam logic [3:0] KMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                       4'h4, 4'h5, 4'h6, 4'hB,
                                       4'h7, 4'h8, 4'h9, 4'hC,
                                       4'hE, 4'h0, 4'hF, 4'hD};

  logic       clk = 1'b0;
  logic       reset;
  logic       cv  [2];
  logic [3:0] ck  [2];
  logic [3:0] cc  [2];
  logic [3:0] rw  [2];
  logic       rdy [2];
  logic       bsy [2];
  logic       dn  [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position within the current press sequence.
  bit         m_busy [2];
  bit         m_done [2];
  int         m_pos  [2];
  logic [7:0] m_lfsr [2];
  logic [3:0] m_key  [2];

  always #5 clk = ~clk;

  keypad_emulator #(.BOUNCE_CYCLES(4), .HOLD_CYCLES(8), .GAP_CYCLES(2)) u_a (
    .clk(clk), .reset(reset), .cols(cc[0]), .rows(rw[0]), .cmd_valid(cv[0]),
    .cmd_key(ck[0]), .cmd_ready(rdy[0]), .busy(bsy[0]), .done(dn[0]));

  keypad_emulator #(.BOUNCE_CYCLES(0), .HOLD_CYCLES(3), .GAP_CYCLES(1)) u_b (
    .clk(clk), .reset(reset), .cols(cc[1]), .rows(rw[1]), .cmd_valid(cv[1]),
    .cmd_key(ck[1]), .cmd_ready(rdy[1]), .busy(bsy[1]), .done(dn[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic bit in_bounce(input int i);
    int p;
    p = m_pos[i];
    return (p < MB[i]) || (p >= MB[i] + MH[i] && p < 2 * MB[i] + MH[i]);
  endfunction

  function automatic logic exp_contact(input int i);
    int p;
    p = m_pos[i];
    if (!m_busy[i])                return 1'b0;
    if (p < MB[i])                 return m_lfsr[i][0];
    if (p < MB[i] + MH[i])         return 1'b1;
    if (p < 2 * MB[i] + MH[i])     return m_lfsr[i][0];
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_rows(input int i);
    int idx;
    logic [3:0] r;
    idx = 0;
    for (int k = 0; k < 16; k++) if (KMAP[k] == m_key[i]) idx = k;
    r = 4'hF;
    if (exp_contact(i) && !cc[i][idx % 4]) r[idx / 4] = 1'b0;
    return r;
  endfunction

  task automatic model_reset(input int i);
    m_busy[i] = 0;
    m_done[i] = 0;
    m_pos[i]  = 0;
    m_lfsr[i] = 8'hA5;
  endtask

  task automatic model_update(input int i);
    if (!reset) begin
      model_reset(i);
      return;
    end
    m_done[i] = 0;
    if (m_busy[i]) begin
      if (in_bounce(i)) m_lfsr[i] = lfsr_step(m_lfsr[i]);
      m_pos[i]++;
      if (m_pos[i] == 2 * MB[i] + MH[i] + MG[i]) begin
        m_busy[i] = 0;
        m_done[i] = 1;
      end
    end else if (cv[i]) begin
      m_busy[i] = 1;
      m_pos[i]  = 0;
      m_key[i]  = ck[i];
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rows%0d", i),  rw[i],  exp_rows(i));
      check($sformatf("ready%0d", i), rdy[i], !m_busy[i]);
      check($sformatf("busy%0d", i),  bsy[i], m_busy[i]);
      check($sformatf("done%0d", i),  dn[i],  m_done[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
    check_all();
  endtask

  task automatic press(input int i, input logic [3:0] key);
    cv[i] = 1'b1;
    ck[i] = key;
    tick();
    cv[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (m_busy[i] && n < 100) begin
      tick();
      n++;
    end
    check($sformatf("idle_wait%0d", i), bsy[i], 1'b0);
  endtask

  initial begin
    int n, cnt, done_at, busy_cnt, done_cnt, pw, w, r2_first, r2_second;
    int tog_o[2], tog_e[2];
    logic po, pe;
    logic [3:0] er;

    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cv[i] = 1'b0; ck[i] = 4'h0; cc[i] = 4'hF; m_key[i] = 4'h0;
      model_reset(i);
    end

    // Scenario 1: reset values, held through reset and after release
    #1;
    check_all();
    tick();
    tick();
    reset = 1'b1;
    check_all();
    tick();
    tick();

    // Scenario 2: key 5, full hold seen on col 1, then column switch mid-hold
    cc[0] = 4'b1101;
    press(0, 4'h5);
    cnt = 0;
    n = 0;
    while (m_busy[0] && n < 40) begin
      if (m_pos[0] >= 4 && m_pos[0] < 12 && rw[0] == 4'b1101) cnt++;
      tick();
      n++;
    end
    check("s2_hold_cycles", cnt, 8);
    wait_idle(0);
    press(0, 4'h5);
    n = 0;
    while (m_pos[0] != 7 && n < 40) begin
      tick();
      n++;
    end
    check("s2_mid_hold_rows", rw[0], 4'b1101);
    cc[0] = 4'b1110;
    #1;
    check("s2_cols_switch", rw[0], 4'hF);
    wait_idle(0);

    // Scenario 3: key D, busy length, single done, bounce chatter on row 3
    cc[0] = 4'b0111;
    press(0, 4'hD);
    busy_cnt = 0; done_cnt = 0; pw = -1; po = 1'b1; pe = 1'b1;
    tog_o = '{0, 0}; tog_e = '{0, 0};
    for (int k = 0; k < 25; k++) begin
      busy_cnt += int'(bsy[0]);
      done_cnt += int'(dn[0]);
      w = (m_busy[0] && m_pos[0] < 4) ? 0 :
          (m_busy[0] && m_pos[0] >= 12 && m_pos[0] < 16) ? 1 : -1;
      er = exp_rows(0);
      if (w >= 0 && w == pw) begin
        if (rw[0][3] != po) tog_o[w]++;
        if (er[3] != pe) tog_e[w]++;
      end
      if (m_busy[0] && m_pos[0] >= 16) check("s3_gap_rows", rw[0], 4'hF);
      pw = w; po = rw[0][3]; pe = er[3];
      tick();
    end
    check("s3_busy_cycles", busy_cnt, 18);
    check("s3_done_pulses", done_cnt, 1);
    check("s3_press_toggles", tog_o[0], tog_e[0]);
    check("s3_release_toggles", tog_o[1], tog_e[1]);

    // Scenario 4: valid held with new key while busy; accepted on done cycle
    cc[0] = 4'b1100;
    cv[0] = 1'b1;
    ck[0] = 4'h1;
    tick();
    ck[0] = 4'h8;
    r2_first = 0; r2_second = 0; n = 0;
    while (!dn[0] && n < 40) begin
      if (!rw[0][2]) r2_first++;
      tick();
      n++;
    end
    check("s4_done_seen", dn[0], 1'b1);
    check("s4_ready_on_done", rdy[0], 1'b1);
    tick();
    cv[0] = 1'b0;
    check("s4_accept_on_done", bsy[0], 1'b1);
    n = 0;
    while (bsy[0] && n < 40) begin
      if (!rw[0][2]) r2_second++;
      tick();
      n++;
    end
    check("s4_row2_first_seq", r2_first, 0);
    check("s4_row2_second_seq", r2_second >= 8, 1'b1);
    wait_idle(0);

    // Scenario 5: asynchronous reset during hold
    cc[0] = 4'b1101;
    press(0, 4'h5);
    n = 0;
    while (m_pos[0] != 6 && n < 40) begin
      tick();
      n++;
    end
    check("s5_before_reset", rw[0], 4'b1101);
    #2;
    reset = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    check("s5_async_rows", rw[0], 4'hF);
    check_all();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) tick();

    // Scenario 6: bounce disabled, key 0 on column 1
    cc[1] = 4'b1101;
    press(1, 4'h0);
    cnt = 0; done_at = -1;
    for (int k = 0; k < 8; k++) begin
      if (rw[1] == 4'b0111) cnt++;
      if (dn[1] && done_at < 0) done_at = k;
      tick();
    end
    check("s6_low_cycles", cnt, 3);
    check("s6_done_offset", done_at, 4);

    // Randomized traffic on both instances, with occasional async reset
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 2; i++) begin
        cv[i] = ($urandom_range(0, 2) == 0);
        ck[i] = 4'($urandom_range(0, 15));
        cc[i] = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 299) == 0) begin
        #2;
        reset = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        check_all();
        tick();
        reset = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Synthesizable 4x4 matrix-keypad model: the responder side of the keypad scan interface. It accepts key-press commands over a valid/ready handshake and drives the row lines in response to the column strobes from `scanfsm`. Each press includes contact bounce on press and on release, a hold period and an inter-key gap. It replaces the physical keypad in simulation and in on-board loopback tests of the scan → debounce → shifter → display chain.

## Interface
Parameters:
- `BOUNCE_CYCLES`, default 1000: cycles of chatter on press and again on release. 0 disables bounce.
- `HOLD_CYCLES`, default 100000: cycles the contact is solidly closed. Must be ≥ 1.
- `GAP_CYCLES`, default 1000: cycles the contact is open before the next command is accepted. Must be ≥ 1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-low. 0 = reset.
- `cols`  in  4: column strobes from the scanner, active-low; bit n = column n.
- `rows`  out  4: row lines to the scanner, active-low with pull-up semantics. 1 = released.
- `cmd_valid`  in  1: a key command is present.
- `cmd_key`  in  4: hex key code.
- `cmd_ready`  out  1: emulator can accept a command.
- `busy`  out  1: a press sequence is in progress.
- `done`  out  1: one-cycle pulse when a sequence completes.

## Operation
- Key map (row, col): 1(0,0) 2(0,1) 3(0,2) A(0,3); 4(1,0) 5(1,1) 6(1,2) B(1,3); 7(2,0) 8(2,1) 9(2,2) C(2,3); E(3,0) 0(3,1) F(3,2) D(3,3).
- Handshake: `cmd_ready` = (state == IDLE). A command is accepted on a rising edge with `cmd_valid & cmd_ready`. `cmd_key` is registered at acceptance. Commands presented while busy are not consumed and need not be held stable.
- States:
  - IDLE → PRESS_BOUNCE on accept, or → HOLD on accept when `BOUNCE_CYCLES` = 0.
  - PRESS_BOUNCE → HOLD after `BOUNCE_CYCLES` cycles.
  - HOLD → RELEASE_BOUNCE after `HOLD_CYCLES` cycles, or → GAP after `HOLD_CYCLES` cycles when `BOUNCE_CYCLES` = 0.
  - RELEASE_BOUNCE → GAP after `BOUNCE_CYCLES` cycles.
  - GAP → IDLE after `GAP_CYCLES` cycles.
- Contact per state: IDLE = 0, PRESS_BOUNCE = `lfsr[0]`, HOLD = 1, RELEASE_BOUNCE = `lfsr[0]`, GAP = 0.
- LFSR: 8-bit, seed 8'hA5 at reset. Advances only in the bounce states, with `lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}`. It is not reseeded between commands.
- Rows: `rows[r]` = 0 iff contact = 1, r = key row and `cols[key col]` = 0. All other rows = 1.
  - This path is combinational from `cols`: no added latency, and it follows any combination of low columns.
  - `cols` is assumed to be synchronous to `clk`.
- `busy` = (state ≠ IDLE). `done` = 1 for exactly the cycle following the GAP → IDLE edge, and `cmd_ready` = 1 in that same cycle.
- Cycle counters are sized to max(`BOUNCE_CYCLES`, `HOLD_CYCLES`, `GAP_CYCLES`). They load on state entry and count down to zero. There is no wrap.

## Timing
- Reset values: `rows` = 4'hF, `cmd_ready` = 1, `busy` = 0, `done` = 0, state = IDLE, lfsr = 8'hA5, counters = 0.
- Reset is asynchronous: asserting it mid-sequence forces `rows` to 4'hF without waiting for a clock edge and aborts the sequence. No `done` pulse is produced.
- Accept at edge k: `busy` = 1 from k. The contact state for PRESS_BOUNCE, or for HOLD when bounce is disabled, is in effect from k.
- Total busy duration = 2·`BOUNCE_CYCLES` + `HOLD_CYCLES` + `GAP_CYCLES` cycles. The earliest next accept is on the edge where `done` is high.

## Structure
- `keypad_pkg` holds:
  - the state enum;
  - the key → {row, col} map function;
  - the LFSR seed and tap constants.
- Sub-module `bounce_lfsr`: 8-bit LFSR with an `en` input and a `bit0` output, asynchronous active-low reset.

## Test plan
Configuration for scenarios 2–5: `BOUNCE_CYCLES` = 4, `HOLD_CYCLES` = 8, `GAP_CYCLES` = 2.
1. Reset low → `rows` = 4'hF, `cmd_ready` = 1, `busy` = 0, `done` = 0. Reset released → values unchanged.
2. Command key 5 with `cols` held at 4'b1101 → `rows` = 4'b1101 on all 8 HOLD cycles. Switching `cols` to 4'b1110 during HOLD → `rows` = 4'hF in the same cycle.
3. Command key D with `cols` = 4'b0111 → `busy` high for 18 cycles. `rows[3]` toggles at least once in each bounce window. `done` pulses once, and `rows` = 4'hF in GAP.
4. Command key 1, with `cmd_valid` held and the key changed to 8 during busy → key 8 is accepted only on the `done` cycle, and `rows[2]` is asserted only during the second sequence.
5. Reset low during HOLD of key 5 → `rows` = 4'hF immediately. After release, state is IDLE, `cmd_ready` = 1, and no `done` pulse occurs.
6. `BOUNCE_CYCLES` = 0, `HOLD_CYCLES` = 3, `GAP_CYCLES` = 1, key 0 with `cols` = 4'b1101 → `rows` = 4'b0111 for exactly 3 cycles from the accept edge, then 4'hF. `done` pulses 4 cycles after accept.
